// File: rtl/rr_mux_arb.sv
// Four-requester round-robin arbiter that also multiplexes the owner's data bus onto Y.
// Define RR_MUX_ARB_TIMEOUT_EN to bound how long one owner can hold the grant.
module rr_mux_arb #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       Req,
    input  logic [3:0]       Last,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    output logic [3:0]       Grant,
    output logic [1:0]       Sel,
    output logic [WIDTH-1:0] Y,
    output logic             Valid,
    output logic             TimeoutErr
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    if ((TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("rr_mux_arb: TIMEOUT must be in 2..65535");
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] sel_nxt;
    logic [3:0] grant_nxt;
    logic [1:0] winner;
    logic       any_req;
    logic       normal_rel;
    logic       abandon;
    logic       release_now;

`ifdef RR_MUX_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             timeout_hit;
`endif

    assign any_req = |Req;

    // Search starts at Sel+1 and wraps; k=4 revisits Sel last so the owner has lowest priority.
    always_comb begin
        winner = Sel;
        for (int k = 4; k >= 1; k--) begin
            if (Req[Sel + 2'(k)]) begin
                winner = Sel + 2'(k);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        sel_nxt     = Sel;
        normal_rel  = 1'b0;
        abandon     = 1'b0;
        release_now = 1'b0;
`ifdef RR_MUX_ARB_TIMEOUT_EN
        cnt_nxt     = cnt;
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BUSY;
                    sel_nxt   = winner;
`ifdef RR_MUX_ARB_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            BUSY: begin
                normal_rel  = Req[Sel] & Last[Sel];
                abandon     = ~Req[Sel];
`ifdef RR_MUX_ARB_TIMEOUT_EN
                timeout_hit = ~normal_rel & ~abandon & (cnt == CNT_W'(TIMEOUT - 1));
                release_now = normal_rel | abandon | timeout_hit;
`else
                release_now = normal_rel | abandon;
`endif
                if (release_now) begin
                    if (any_req) begin
                        sel_nxt = winner;
                    end else begin
                        state_nxt = IDLE;
                    end
`ifdef RR_MUX_ARB_TIMEOUT_EN
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered grant follows the next owner index
    always_comb begin
        grant_nxt = 4'b0000;
        if (state_nxt == BUSY) begin
            grant_nxt = 4'(4'b0001 << sel_nxt);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            Sel   <= 2'b11;
            Grant <= 4'b0000;
        end else begin
            state <= state_nxt;
            Sel   <= sel_nxt;
            Grant <= grant_nxt;
        end
    end

`ifdef RR_MUX_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= '0;
            TimeoutErr <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            TimeoutErr <= timeout_hit;
        end
    end
`else
    assign TimeoutErr = 1'b0;
`endif

    // Data path: owner's bus when it is presenting a beat, zero otherwise
    always_comb begin
        Valid = (state == BUSY) & Req[Sel];
        Y     = '0;
        if (Valid) begin
            case (Sel)
                2'd0:    Y = D0;
                2'd1:    Y = D1;
                2'd2:    Y = D2;
                default: Y = D3;
            endcase
        end
    end

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter: WIDTH, 32, data width of each requester's data bus and of the shared output.
REQ-002 Parameter: TIMEOUT, 16, maximum cycles one owner may hold the grant (used only with RR_MUX_ARB_TIMEOUT_EN; legal range 2..65535).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  synchronous, active-low reset.
REQ-005 Port: Req  input  4  per-requester request; bit i belongs to requester i.
REQ-006 Port: Last  input  4  per-requester end-of-transaction flag; sampled only when that requester is granted and its Req is high.
REQ-007 Port: D0, D1, D2, D3  input  WIDTH each  requester data buses.
REQ-008 Port: Grant  output  4  one-hot registered grant, or all-zero.
REQ-009 Port: Sel  output  2  registered binary index of the current or last owner; drives downstream mux4 select.
REQ-010 Port: Y  output  WIDTH  D[Sel] when Valid, else all-zero.
REQ-011 Port: Valid  output  1  Busy AND Req[Sel]; marks a beat on Y.
REQ-012 Port: TimeoutErr  output  1  one-cycle pulse on forced release.

Function
REQ-013 FSM SHALL have two states: IDLE (Grant=0) and BUSY (Grant=onehot(Sel)).
REQ-014 Priority SHALL be round-robin: search order starts at index Sel+1 mod 4 and wraps, so the current owner has lowest priority.
REQ-015 In IDLE, if any Req bit is high at an edge, the block SHALL load the round-robin winner into Sel and enter BUSY; Grant is visible in the next cycle (one-cycle latency).
REQ-016 In IDLE with Req=0, state, Sel and Grant SHALL hold.
REQ-017 In BUSY, the grant SHALL be released at an edge when Req[Sel]&Last[Sel] (normal completion) or when Req[Sel]=0 (abandon).
REQ-018 On release, if any Req bit is high (the departing owner included, at lowest priority), the block SHALL grant the new winner at the same edge and stay in BUSY (no idle bubble); otherwise it SHALL enter IDLE and keep Sel.
REQ-019 While BUSY and not releasing, Grant and Sel SHALL hold regardless of other requests; there is no preemption.
REQ-020 Last SHALL be ignored for non-owners and while in IDLE.
REQ-021 Y and Valid SHALL be combinational from registered Sel/state and current Req/D.

Reset
REQ-022 With reset_n low at an edge: state=IDLE, Grant=0, Sel=2'b11 (first winner search starts at requester 0), TimeoutErr=0, timeout counter=0.
REQ-023 Reset mid-transaction SHALL drop Grant at the same edge with no TimeoutErr pulse; Valid and Y SHALL be 0 in the following cycle.

Configuration
REQ-024 With macro RR_MUX_ARB_TIMEOUT_EN defined, a counter SHALL clear on every new grant and increment each BUSY cycle without release; when it equals TIMEOUT-1 and no normal release occurs, the block SHALL force release per REQ-018 and pulse TimeoutErr for exactly one cycle.
REQ-025 Without RR_MUX_ARB_TIMEOUT_EN, the block SHALL contain no counter, TimeoutErr SHALL be tied to 0, and ownership SHALL be unbounded.

Verification
REQ-026 Reset, then Req=4'b0101 -> next cycle Grant=0001, Sel=0; after Last[0] edge -> Grant=0100, Sel=2 with no idle cycle.
REQ-027 Req=4'b1111 held, every owner asserts Last on its first beat -> grant sequence 0,1,2,3,0 on consecutive cycles.
REQ-028 Owner 1 holds Req without Last for 10 cycles while Req[3]=1 -> Grant stays 0010 throughout; Y equals D1 whenever Valid=1.
REQ-029 Owner 2 drops Req with no other requests -> next cycle IDLE, Grant=0, Sel=2, Valid=0, Y=0.
REQ-030 TIMEOUT_EN, TIMEOUT=16, owner 0 never asserts Last and Req[1]=1 -> forced release to requester 1 after 16 BUSY cycles, TimeoutErr high for 1 cycle; without the macro, owner 0 is held through 100 cycles and TimeoutErr stays 0.
REQ-031 reset_n low during a BUSY beat -> Grant=0 next cycle, TimeoutErr=0; after reset, Req=4'b1000 -> grant to requester 3.
